// File: rtl/map_table.sv
// Register rename map table: speculative map, ready bits and architectural map.
// Single-preg-per-cycle rename with CDB wakeup, ROB retire and mispredict recovery.
module map_table (
    input  logic       clk,
    input  logic       rst,
    input  logic       dispatch_en_i,
    input  logic [4:0] rs1_idx_i,
    input  logic [4:0] rs2_idx_i,
    input  logic [4:0] rd_idx_i,
    input  logic       rd_vld_i,
    input  logic       free_preg_vld_i,
    input  logic [5:0] free_preg_i,
    input  logic       cdb_vld_i,
    input  logic [5:0] cdb_tag_i,
    input  logic       retire_en_i,
    input  logic [4:0] retire_rd_idx_i,
    input  logic [5:0] retire_preg_i,
    input  logic       recover_en_i,
    output logic [5:0] rs1_preg_o,
    output logic [5:0] rs2_preg_o,
    output logic       rs1_rdy_o,
    output logic       rs2_rdy_o,
    output logic [5:0] rd_old_preg_o,
    output logic       rename_stall_o
);

    logic [5:0]  sm      [32];
    logic [5:0]  am      [32];
    logic [31:0] rdy;

    logic [5:0]  sm_next [32];
    logic [5:0]  am_next [32];
    logic [31:0] rdy_next;

    logic        rename_req;
    logic        rename_we;
    logic        retire_we;
    logic [5:0]  rs1_map;
    logic [5:0]  rs2_map;

    assign rename_req = dispatch_en_i & rd_vld_i & (rd_idx_i != '0);
    assign rename_we  = rename_req & free_preg_vld_i & ~recover_en_i;
    assign retire_we  = retire_en_i & (retire_rd_idx_i != '0);

    // Lookups see the map as it stood at the start of the cycle, so rs==rd
    // returns the old mapping.
    assign rs1_map = sm[rs1_idx_i];
    assign rs2_map = sm[rs2_idx_i];

    assign rs1_preg_o = rs1_map;
    assign rs2_preg_o = rs2_map;
    assign rs1_rdy_o  = rdy[rs1_idx_i] | (cdb_vld_i & (cdb_tag_i == rs1_map));
    assign rs2_rdy_o  = rdy[rs2_idx_i] | (cdb_vld_i & (cdb_tag_i == rs2_map));

    assign rd_old_preg_o  = (dispatch_en_i & rd_vld_i) ? sm[rd_idx_i] : '0;
    assign rename_stall_o = recover_en_i | (rename_req & ~free_preg_vld_i);

    always_comb begin
        am_next  = am;
        sm_next  = sm;
        rdy_next = rdy;

        if (retire_we)
            am_next[retire_rd_idx_i] = retire_preg_i;

        if (recover_en_i) begin
            // Restore from the architectural map including this cycle's retire.
            sm_next  = am_next;
            rdy_next = '1;
        end else begin
            if (cdb_vld_i) begin
                for (int unsigned i = 0; i < 32; i++) begin
                    if (sm[5'(i)] == cdb_tag_i)
                        rdy_next[5'(i)] = 1'b1;
                end
            end
            // Applied after wakeup so a same-cycle rename clear wins.
            if (rename_we) begin
                sm_next[rd_idx_i]  = free_preg_i;
                rdy_next[rd_idx_i] = 1'b0;
            end
        end

        sm_next[0]  = '0;
        am_next[0]  = '0;
        rdy_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                sm[5'(i)] <= 6'(i);
                am[5'(i)] <= 6'(i);
            end
            rdy <= '1;
        end else begin
            sm  <= sm_next;
            am  <= am_next;
            rdy <= rdy_next;
        end
    end

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: expected outputs are queued when a step is
// driven and popped against the DUT outputs at the following falling edge.
module tb_map_table;

    logic       clk;
    logic       rst;
    logic       dispatch_en_i;
    logic [4:0] rs1_idx_i;
    logic [4:0] rs2_idx_i;
    logic [4:0] rd_idx_i;
    logic       rd_vld_i;
    logic       free_preg_vld_i;
    logic [5:0] free_preg_i;
    logic       cdb_vld_i;
    logic [5:0] cdb_tag_i;
    logic       retire_en_i;
    logic [4:0] retire_rd_idx_i;
    logic [5:0] retire_preg_i;
    logic       recover_en_i;
    logic [5:0] rs1_preg_o;
    logic [5:0] rs2_preg_o;
    logic       rs1_rdy_o;
    logic       rs2_rdy_o;
    logic [5:0] rd_old_preg_o;
    logic       rename_stall_o;

    map_table dut (
        .clk             (clk),
        .rst             (rst),
        .dispatch_en_i   (dispatch_en_i),
        .rs1_idx_i       (rs1_idx_i),
        .rs2_idx_i       (rs2_idx_i),
        .rd_idx_i        (rd_idx_i),
        .rd_vld_i        (rd_vld_i),
        .free_preg_vld_i (free_preg_vld_i),
        .free_preg_i     (free_preg_i),
        .cdb_vld_i       (cdb_vld_i),
        .cdb_tag_i       (cdb_tag_i),
        .retire_en_i     (retire_en_i),
        .retire_rd_idx_i (retire_rd_idx_i),
        .retire_preg_i   (retire_preg_i),
        .recover_en_i    (recover_en_i),
        .rs1_preg_o      (rs1_preg_o),
        .rs2_preg_o      (rs2_preg_o),
        .rs1_rdy_o       (rs1_rdy_o),
        .rs2_rdy_o       (rs2_rdy_o),
        .rd_old_preg_o   (rd_old_preg_o),
        .rename_stall_o  (rename_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [6:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string field, input logic [6:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%0d", field, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_out(input string step,
                              input int p1, input int r1,
                              input int p2, input int r2,
                              input int old, input int stall);
        push({step, ".rs1_preg"}, 7'(p1));
        push({step, ".rs1_rdy"},  7'(r1));
        push({step, ".rs2_preg"}, 7'(p2));
        push({step, ".rs2_rdy"},  7'(r2));
        push({step, ".rd_old"},   7'(old));
        push({step, ".stall"},    7'(stall));
    endtask

    task automatic idle();
        rst             = 1'b0;
        dispatch_en_i   = 1'b0;
        rs1_idx_i       = '0;
        rs2_idx_i       = '0;
        rd_idx_i        = '0;
        rd_vld_i        = 1'b0;
        free_preg_vld_i = 1'b0;
        free_preg_i     = '0;
        cdb_vld_i       = 1'b0;
        cdb_tag_i       = '0;
        retire_en_i     = 1'b0;
        retire_rd_idx_i = '0;
        retire_preg_i   = '0;
        recover_en_i    = 1'b0;
    endtask

    // Sample at the falling edge, then let the rising edge commit the step.
    task automatic sample_and_advance();
        @(negedge clk);
        pop_check("rs1_preg", {1'b0, rs1_preg_o});
        pop_check("rs1_rdy",  {6'b0, rs1_rdy_o});
        pop_check("rs2_preg", {1'b0, rs2_preg_o});
        pop_check("rs2_rdy",  {6'b0, rs2_rdy_o});
        pop_check("rd_old",   {1'b0, rd_old_preg_o});
        pop_check("stall",    {6'b0, rename_stall_o});
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] rd, input logic [5:0] preg);
        dispatch_en_i   = 1'b1;
        rd_vld_i        = 1'b1;
        rd_idx_i        = rd;
        free_preg_vld_i = 1'b1;
        free_preg_i     = preg;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle();

        // Reset state; rd_vld without dispatch gives no Told
        rs1_idx_i = 5'd3; rs2_idx_i = 5'd31; rd_idx_i = 5'd5; rd_vld_i = 1'b1;
        expect_out("S01", 3, 1, 31, 1, 0, 0);
        sample_and_advance();

        // rd=5 -> 40 with rs1=5 reading the old mapping
        rename(5'd5, 6'd40); rs1_idx_i = 5'd5;
        expect_out("S02", 5, 1, 0, 1, 5, 0);
        sample_and_advance();

        rs1_idx_i = 5'd5; rs2_idx_i = 5'd5;
        expect_out("S03", 40, 0, 40, 0, 0, 0);
        sample_and_advance();

        // CDB bypass on tag 40, then registered ready
        cdb_vld_i = 1'b1; cdb_tag_i = 6'd40; rs2_idx_i = 5'd5;
        expect_out("S04", 0, 1, 40, 1, 0, 0);
        sample_and_advance();

        rs1_idx_i = 5'd5; rs2_idx_i = 5'd5;
        expect_out("S05", 40, 1, 40, 1, 0, 0);
        sample_and_advance();

        // No free preg: stall, SM[7] untouched
        dispatch_en_i = 1'b1; rd_vld_i = 1'b1; rd_idx_i = 5'd7;
        free_preg_i = 6'd44; rs1_idx_i = 5'd7;
        expect_out("S06", 7, 1, 0, 1, 7, 1);
        sample_and_advance();

        rs1_idx_i = 5'd7;
        expect_out("S07", 7, 1, 0, 1, 0, 0);
        sample_and_advance();

        // rd=0 never stalls and never consumes a preg
        dispatch_en_i = 1'b1; rd_vld_i = 1'b1; rd_idx_i = 5'd0;
        expect_out("S08", 0, 1, 0, 1, 0, 0);
        sample_and_advance();

        rename(5'd0, 6'd50);
        expect_out("S09", 0, 1, 0, 1, 0, 0);
        sample_and_advance();

        rs1_idx_i = 5'd0; rs2_idx_i = 5'd7;
        expect_out("S10", 0, 1, 7, 1, 0, 0);
        sample_and_advance();

        // Rename 3->41, 4->42, retire 3
        rename(5'd3, 6'd41); rs1_idx_i = 5'd3;
        expect_out("S11", 3, 1, 0, 1, 3, 0);
        sample_and_advance();

        rename(5'd4, 6'd42); rs1_idx_i = 5'd3; rs2_idx_i = 5'd4;
        expect_out("S12", 41, 0, 4, 1, 4, 0);
        sample_and_advance();

        retire_en_i = 1'b1; retire_rd_idx_i = 5'd3; retire_preg_i = 6'd41;
        rs1_idx_i = 5'd4; rs2_idx_i = 5'd3;
        expect_out("S13", 42, 0, 41, 0, 0, 0);
        sample_and_advance();

        // Recover with same-cycle retire; dispatch and CDB ignored
        recover_en_i = 1'b1;
        retire_en_i = 1'b1; retire_rd_idx_i = 5'd4; retire_preg_i = 6'd42;
        rename(5'd6, 6'd43);
        cdb_vld_i = 1'b1; cdb_tag_i = 6'd42;
        rs1_idx_i = 5'd3; rs2_idx_i = 5'd4;
        expect_out("S14", 41, 0, 42, 1, 6, 1);
        sample_and_advance();

        rs1_idx_i = 5'd3; rs2_idx_i = 5'd4;
        expect_out("S15", 41, 1, 42, 1, 0, 0);
        sample_and_advance();

        rs1_idx_i = 5'd5; rs2_idx_i = 5'd6;
        expect_out("S16", 5, 1, 6, 1, 0, 0);
        sample_and_advance();

        // Rename clear beats CDB match on the old mapping
        rename(5'd9, 6'd45); cdb_vld_i = 1'b1; cdb_tag_i = 6'd9; rs1_idx_i = 5'd9;
        expect_out("S17", 9, 1, 0, 1, 9, 0);
        sample_and_advance();

        rs1_idx_i = 5'd9;
        expect_out("S18", 45, 0, 0, 1, 0, 0);
        sample_and_advance();

        cdb_vld_i = 1'b1; cdb_tag_i = 6'd45; rs1_idx_i = 5'd9;
        expect_out("S19", 45, 1, 0, 1, 0, 0);
        sample_and_advance();

        // Retire to r0 ignored, survives recovery
        retire_en_i = 1'b1; retire_rd_idx_i = 5'd0; retire_preg_i = 6'd55;
        rs1_idx_i = 5'd9;
        expect_out("S20", 45, 1, 0, 1, 0, 0);
        sample_and_advance();

        recover_en_i = 1'b1; rs1_idx_i = 5'd9;
        expect_out("S21", 45, 1, 0, 1, 0, 1);
        sample_and_advance();

        rs1_idx_i = 5'd9; rs2_idx_i = 5'd0;
        expect_out("S22", 9, 1, 0, 1, 0, 0);
        sample_and_advance();

        // Reset overrides recover/retire/dispatch
        rename(5'd10, 6'd46); rs1_idx_i = 5'd10;
        expect_out("S23", 10, 1, 0, 1, 10, 0);
        sample_and_advance();

        rst = 1'b1; recover_en_i = 1'b1;
        rename(5'd11, 6'd47);
        retire_en_i = 1'b1; retire_rd_idx_i = 5'd12; retire_preg_i = 6'd48;
        rs1_idx_i = 5'd10; rs2_idx_i = 5'd11;
        expect_out("S24", 46, 0, 11, 1, 11, 1);
        sample_and_advance();

        rs1_idx_i = 5'd10; rs2_idx_i = 5'd11;
        expect_out("S25", 10, 1, 11, 1, 0, 0);
        sample_and_advance();

        // Architectural map was reset too: recovery restores identity
        recover_en_i = 1'b1; rs1_idx_i = 5'd3; rs2_idx_i = 5'd4;
        expect_out("S26", 3, 1, 4, 1, 0, 1);
        sample_and_advance();

        rs1_idx_i = 5'd3; rs2_idx_i = 5'd12;
        expect_out("S27", 3, 1, 12, 1, 0, 0);
        sample_and_advance();

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: dispatch_en_i  input  1  [Decoder] valid instruction to rename this cycle.
REQ-004 SHALL: rs1_idx_i, rs2_idx_i  input  5 each  source arch regs.
REQ-005 SHALL: rd_idx_i  input  5  destination arch reg; rd_vld_i  input  1  instruction writes rd.
REQ-006 SHALL: free_preg_vld_i  input  1, free_preg_i  input  6  [Free List] new preg offered.
REQ-007 SHALL: cdb_vld_i  input  1, cdb_tag_i  input  6  [CDB] completed preg broadcast.
REQ-008 SHALL: retire_en_i  input  1, retire_rd_idx_i  input  5, retire_preg_i  input  6  [ROB] committed mapping.
REQ-009 SHALL: recover_en_i  input  1  [ROB] mispredict; restore speculative map from architectural map.
REQ-010 SHALL: rs1_preg_o, rs2_preg_o  output  6 each; rs1_rdy_o, rs2_rdy_o  output  1 each  [RS] source tags and ready bits.
REQ-011 SHALL: rd_old_preg_o  output  6  [ROB] previous mapping of rd (Told).
REQ-012 SHALL: rename_stall_o  output  1  [Decoder] rename blocked this cycle.

Function
REQ-013 SHALL: hold spec map SM[32] of 6-bit pregs, ready bits RDY[32], architectural map AM[32] of 6-bit pregs.
REQ-014 SHALL: drive all outputs combinationally from current-cycle state/inputs; zero-latency lookup.
REQ-015 SHALL: rsN_preg_o = SM[rsN_idx_i] before any same-cycle write (rs==rd reads old mapping).
REQ-016 SHALL: rsN_rdy_o = RDY[rsN_idx_i] OR (cdb_vld_i AND cdb_tag_i == SM[rsN_idx_i]) (CDB bypass).
REQ-017 SHALL: rd_old_preg_o = SM[rd_idx_i] before write when dispatch_en_i & rd_vld_i, else 0.
REQ-018 SHALL: arch reg 0 hardwired: SM[0]=AM[0]=0, RDY[0]=1; writes with rd or retire_rd = 0 ignored, no free preg consumed.
REQ-019 SHALL: rename write when dispatch_en_i & rd_vld_i & rd_idx_i!=0 & free_preg_vld_i & ~recover_en_i: SM[rd]<=free_preg_i, RDY[rd]<=0.
REQ-020 SHALL: rename_stall_o = recover_en_i OR (dispatch_en_i & rd_vld_i & rd_idx_i!=0 & ~free_preg_vld_i); no state change from dispatch while stalled.
REQ-021 SHALL: on cdb_vld_i, set RDY[i]<=1 for every i with SM[i]==cdb_tag_i, except the entry renamed same cycle (rename clear wins).
REQ-022 SHALL: on retire_en_i & retire_rd_idx_i!=0, AM[retire_rd_idx_i]<=retire_preg_i.
REQ-023 SHALL: on recover_en_i, SM[i]<=AM'[i] for all i, where AM' includes any same-cycle retire write; RDY[i]<=1 for all i; dispatch and CDB ignored that cycle.
REQ-024 SHALL: priority rst > recover_en_i > normal (rename/CDB/retire concurrent).
REQ-025 SHALL: never allocate more than one preg per cycle; scalar rename.

Reset
REQ-026 SHALL: on rst, SM[i]<=i, AM[i]<=i, RDY[i]<=1 for i=0..31; pregs 32..63 owned by Free List.
REQ-027 SHALL: after reset with dispatch_en_i=0: rsN_preg_o={0,rsN_idx_i}, rsN_rdy_o=1, rd_old_preg_o=0, rename_stall_o=0.
REQ-028 SHALL: rst mid-operation discards all speculative and architectural mappings in one cycle, overriding recover/retire/dispatch.

Verification
REQ-029 SHALL: reset; dispatch rd=5, rs1=5, free_preg=40 -> rs1_preg_o=5, rd_old_preg_o=5; next cycle rs1=5 -> preg 40, rdy 0.
REQ-030 SHALL: SM[5]=40 not ready; cdb_vld_i, tag 40 same cycle as lookup rs2=5 -> rs2_rdy_o=1; following cycle RDY[5]=1.
REQ-031 SHALL: dispatch rd=7, free_preg_vld_i=0 -> rename_stall_o=1, SM[7] unchanged; rd=0 with free_preg_vld_i=0 -> no stall, SM[0]=0.
REQ-032 SHALL: rename rd=3->41, rd=4->42; retire rd=3 preg 41; recover same cycle as retire rd=4 preg 42 -> SM[3]=41, SM[4]=42, all RDY=1, rename_stall_o=1.
REQ-033 SHALL: rename rd=9->45 with cdb_tag_i=9 (old mapping) same cycle -> SM[9]=45, RDY[9]=0.
REQ-034 SHALL: rst asserted with recover_en_i and dispatch_en_i -> all SM[i]=i, RDY=1 next cycle.
